// File: rtl/keystream_gen.sv
`default_nettype none
// keystream_gen: 32-bit key loader feeding a Galois LFSR that emits one keystream byte per valid/ready handshake.
// Build option KEYSTREAM_PREFETCH_EN adds a second byte buffer so generation overlaps the output hold.
module keystream_gen #(
   parameter int                LFSR_W = 32,
   parameter logic [LFSR_W-1:0] TAPS   = 32'h80200003,
   parameter int                WARMUP = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] key_in,
   input  logic       key_we,
   input  logic       key_go,
   input  logic       resync,
   output logic [7:0] ks_byte,
   output logic       ks_valid,
   input  logic       ks_ready,
   output logic       busy
);
   localparam int KEY_BYTES = LFSR_W / 8;
   localparam int KEY_W     = KEY_BYTES * 8;
   localparam int WCW       = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam logic [WCW-1:0] WLAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WARMUP = 2'd1,
      S_GEN    = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [KEY_W-1:0]  r_key;
   logic [LFSR_W-1:0] r_lfsr;
   logic [LFSR_W-1:0] w_lfsr_step;
   logic [LFSR_W-1:0] w_seed;
   logic [WCW-1:0]    r_wcnt;
   logic [2:0]        r_bitcnt;
   logic [7:0]        r_shift;
   logic [7:0]        w_byte_new;
   logic [7:0]        r_ks_byte;
   logic              r_ks_valid;
   logic              w_done;
   logic              w_pop;
`ifdef KEYSTREAM_PREFETCH_EN
   logic [7:0]        r_buf;
   logic              r_buf_vld;
`endif

   assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
   // An all-zero key would lock the LFSR at zero forever.
   assign w_seed      = (r_key == '0) ? LFSR_W'(1) : r_key;
   assign w_byte_new  = {r_shift[6:0], r_lfsr[0]};
   assign w_done      = (r_state == S_GEN) && (r_bitcnt == 3'd7) && !resync;
   assign w_pop       = r_ks_valid && ks_ready;

   always_comb begin
      w_state_nxt = r_state;
      if (resync) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:   if (key_go) w_state_nxt = (WARMUP == 0) ? S_GEN : S_WARMUP;
            S_WARMUP: if (r_wcnt == WLAST) w_state_nxt = S_GEN;
`ifdef KEYSTREAM_PREFETCH_EN
            // Stop only when the output register and the spare buffer are both occupied.
            S_GEN:    if (w_done && r_ks_valid && !w_pop) w_state_nxt = S_HOLD;
`else
            S_GEN:    if (w_done) w_state_nxt = S_HOLD;
`endif
            S_HOLD:   if (ks_ready) w_state_nxt = S_GEN;
            default:  w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key    <= '0;
         r_lfsr   <= '0;
         r_wcnt   <= '0;
         r_bitcnt <= '0;
         r_shift  <= '0;
      end else if (resync) begin
         r_wcnt   <= '0;
         r_bitcnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (key_go) begin
                  r_lfsr   <= w_seed;
                  r_wcnt   <= '0;
                  r_bitcnt <= '0;
               end else if (key_we) begin
                  r_key <= {r_key[KEY_W-9:0], key_in};
               end
            end
            S_WARMUP: begin
               r_lfsr <= w_lfsr_step;
               r_wcnt <= r_wcnt + WCW'(1);
            end
            S_GEN: begin
               r_lfsr   <= w_lfsr_step;
               r_shift  <= w_byte_new;
               r_bitcnt <= r_bitcnt + 3'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef KEYSTREAM_PREFETCH_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ks_byte  <= '0;
         r_ks_valid <= 1'b0;
         r_buf      <= '0;
         r_buf_vld  <= 1'b0;
      end else if (resync) begin
         r_ks_valid <= 1'b0;
         r_buf_vld  <= 1'b0;
      end else begin
         case ({w_done, w_pop})
            2'b11: begin
               if (r_buf_vld) begin
                  r_ks_byte <= r_buf;
                  r_buf     <= w_byte_new;
               end else begin
                  r_ks_byte <= w_byte_new;
               end
            end
            2'b10: begin
               if (!r_ks_valid) begin
                  r_ks_byte  <= w_byte_new;
                  r_ks_valid <= 1'b1;
               end else begin
                  r_buf      <= w_byte_new;
                  r_buf_vld  <= 1'b1;
               end
            end
            2'b01: begin
               if (r_buf_vld) begin
                  r_ks_byte <= r_buf;
                  r_buf_vld <= 1'b0;
               end else begin
                  r_ks_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ks_byte  <= '0;
         r_ks_valid <= 1'b0;
      end else if (resync) begin
         r_ks_valid <= 1'b0;
      end else if (w_done) begin
         r_ks_byte  <= w_byte_new;
         r_ks_valid <= 1'b1;
      end else if (w_pop) begin
         r_ks_valid <= 1'b0;
      end
   end
`endif

   assign ks_byte  = r_ks_byte;
   assign ks_valid = r_ks_valid;
   assign busy     = (r_state == S_WARMUP) || (r_state == S_GEN);

endmodule
`default_nettype wire

// File: tb/tb_keystream_gen.sv
`default_nettype none
// tb_keystream_gen: directed checks of keystream_gen (WARMUP=0 and default instances) against a small LFSR model.
module tb_keystream_gen;
`ifdef KEYSTREAM_PREFETCH_EN
   localparam int SPACING = 8;
`else
   localparam int SPACING = 9;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] key_in, k0_key_in;
   logic       key_we, key_go, resync, ks_ready;
   logic       k0_we, k0_go, k0_resync, k0_ready;
   logic [7:0] ks_byte, k0_byte;
   logic       ks_valid, busy, k0_valid, k0_busy;

   int          errors = 0;
   int          checks = 0;
   int          n, bad, nlo;
   logic [7:0]  b, e;
   logic [31:0] m_s;
   logic [31:0] kw;

   always #5 clk = ~clk;

   keystream_gen #(.WARMUP(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .key_in(k0_key_in), .key_we(k0_we), .key_go(k0_go),
      .resync(k0_resync), .ks_byte(k0_byte), .ks_valid(k0_valid), .ks_ready(k0_ready), .busy(k0_busy)
   );

   keystream_gen u_dut (
      .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_we(key_we), .key_go(key_go),
      .resync(resync), .ks_byte(ks_byte), .ks_valid(ks_valid), .ks_ready(ks_ready), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] lstep(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
   endfunction

   task automatic model_seed(input logic [31:0] k, input int warm);
      m_s = (k == 32'd0) ? 32'd1 : k;
      repeat (warm) m_s = lstep(m_s);
   endtask

   task automatic model_next(output logic [7:0] bb);
      bb = 8'h00;
      repeat (8) begin
         bb  = {bb[6:0], m_s[0]};
         m_s = lstep(m_s);
      end
   endtask

   // Waits (bounded) for ks_valid, captures the byte, then completes one handshake.
   task automatic read_byte(input string tag, output logic [7:0] bb);
      int w;
      w = 0;
      while (!ks_valid && w < 300) begin
         tick();
         w++;
      end
      if (!ks_valid) check({tag, "_timeout"}, 32'(ks_valid), 32'd1);
      bb       = ks_byte;
      ks_ready = 1'b1;
      tick();
      ks_ready = 1'b0;
   endtask

   task automatic load_key(input logic [31:0] k);
      for (int i = 0; i < 4; i++) begin
         key_in = k[31 - 8*i -: 8];
         key_we = 1'b1;
         tick();
         key_we = 1'b0;
      end
   endtask

   task automatic pulse_resync();
      resync = 1'b1;
      tick();
      resync = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      key_in = 8'h00; key_we = 1'b0; key_go = 1'b0; resync = 1'b0; ks_ready = 1'b0;
      k0_key_in = 8'h00; k0_we = 1'b0; k0_go = 1'b0; k0_resync = 1'b0; k0_ready = 1'b0;
      tick();
      tick();
      check("rst_valid", 32'(ks_valid), 32'd0);
      check("rst_byte", 32'(ks_byte), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_k0_valid", 32'(k0_valid), 32'd0);
      rst_n = 1'b1;
      tick();

      // Scenario 1: WARMUP=0, zero key, ready held high.
      k0_ready = 1'b1;
      k0_go    = 1'b1;
      tick();
      k0_go    = 1'b0;
      check("t1_busy", 32'(k0_busy), 32'd1);
      n = 0;
      while (!k0_valid && n < 50) begin
         tick();
         n++;
      end
      check("t1_latency", 32'(n), 32'd8);
      check("t1_byte0", 32'(k0_byte), 32'hDB);
      model_seed(32'd0, 0);
      model_next(e);
      model_next(e);
      tick();
      check("t1_drop", 32'(k0_valid), 32'd0);
      n = 1;
      while (!k0_valid && n < 50) begin
         tick();
         n++;
      end
      check("t1_spacing", 32'(n), 32'(SPACING));
      check("t1_byte1", 32'(k0_byte), 32'(e));
      k0_ready  = 1'b0;
      k0_resync = 1'b1;
      tick();
      k0_resync = 1'b0;
      check("t1_resync_valid", 32'(k0_valid), 32'd0);
      check("t1_resync_busy", 32'(k0_busy), 32'd0);

      // Scenario 2: default WARMUP, all-zero key bytes, latency and busy.
      load_key(32'h00000000);
      key_go = 1'b1;
      tick();
      key_go = 1'b0;
      check("t2_busy", 32'(busy), 32'd1);
      n = 0;
      nlo = 0;
      while (!ks_valid && n < 200) begin
         tick();
         n++;
         if (!busy && !ks_valid) nlo++;
      end
      check("t2_latency", 32'(n), 32'd72);
      check("t2_busy_gaps", 32'(nlo), 32'd0);
      model_seed(32'd0, 64);
      model_next(e);
      check("t2_byte0", 32'(ks_byte), 32'(e));

      // Scenario 3: stall 20 cycles, output held, LFSR frozen.
      b   = ks_byte;
      bad = 0;
      repeat (20) begin
         tick();
         if (!ks_valid || ks_byte !== b) bad++;
      end
      check("t3_hold", 32'(bad), 32'd0);
      check("t3_busy_idle", 32'(busy), 32'd0);
      ks_ready = 1'b1;
      tick();
      ks_ready = 1'b0;
      read_byte("t3_b1", b);
      model_next(e);
      check("t3_byte1", 32'(b), 32'(e));

      // resync beats a same-cycle handshake: no further bytes appear.
      read_byte("t3_b2", b);
      model_next(e);
      check("t3_byte2", 32'(b), 32'(e));
      n = 0;
      while (!ks_valid && n < 50) begin
         tick();
         n++;
      end
      ks_ready = 1'b1;
      resync   = 1'b1;
      tick();
      ks_ready = 1'b0;
      resync   = 1'b0;
      bad = 0;
      repeat (20) begin
         tick();
         if (ks_valid || busy) bad++;
      end
      check("t3_resync_prio", 32'(bad), 32'd0);

      // Scenario 4: key DEADBEEF, 16 bytes, then resync and rerun.
      kw = 32'hDEADBEEF;
      load_key(kw);
      key_go = 1'b1;
      tick();
      key_go = 1'b0;
      model_seed(kw, 64);
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         read_byte("t4_run1", b);
         model_next(e);
         if (b !== e) bad++;
      end
      check("t4_run1_bytes", 32'(bad), 32'd0);

      // Scenario 6 folded into the rerun: key_we/key_go pulses during WARMUP are ignored.
      pulse_resync();
      key_go = 1'b1;
      tick();
      key_go = 1'b0;
      repeat (5) tick();
      key_in = 8'h55;
      key_we = 1'b1;
      key_go = 1'b1;
      tick();
      key_we = 1'b0;
      key_go = 1'b0;
      model_seed(kw, 64);
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         read_byte("t4_run2", b);
         model_next(e);
         if (b !== e) bad++;
      end
      check("t4_run2_bytes", 32'(bad), 32'd0);

      pulse_resync();
      key_go = 1'b1;
      tick();
      key_go = 1'b0;
      model_seed(kw, 64);
      read_byte("t6_key_kept0", b);
      model_next(e);
      check("t6_key_kept0", 32'(b), 32'(e));
      read_byte("t6_key_kept1", b);
      model_next(e);
      check("t6_key_kept1", 32'(b), 32'(e));

      // Scenario 5: asynchronous reset mid-GEN.
      pulse_resync();
      key_go = 1'b1;
      tick();
      key_go = 1'b0;
      repeat (68) tick();
      check("t5_busy_before", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(ks_valid), 32'd0);
      check("t5_rst_byte", 32'(ks_byte), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      key_go = 1'b1;
      tick();
      key_go = 1'b0;
      n = 0;
      while (!ks_valid && n < 200) begin
         tick();
         n++;
      end
      check("t5_latency", 32'(n), 32'd72);
      model_seed(32'd0, 64);
      model_next(e);
      check("t5_byte0", 32'(ks_byte), 32'(e));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
